uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 SHALL have port UART_load  input  1  byte-load strobe from processor, one cycle per byte.
REQ-005 SHALL have port UART_din  input  8  byte to transmit, sampled when a load is accepted.
REQ-006 SHALL have port UART_TE  output  1  transmit-holding-register empty; high = a load will be accepted.
REQ-007 SHALL have port UART_TXD  output  1  serial line, idle high, registered output.
REQ-008 SHALL have port UART_busy  output  1  high while a frame is on the line (state not IDLE).

Function
REQ-009 SHALL contain a one-byte holding register (THR) with valid flag; UART_TE = NOT THR-valid, combinationally.
REQ-010 SHALL accept a load when UART_load=1 and UART_TE=1 at an edge: THR <= UART_din, THR-valid <= 1.
REQ-011 SHALL ignore UART_load while UART_TE=0: THR, its valid flag and the line are unaffected, the byte is dropped.
REQ-012 SHALL implement shifter FSM states IDLE, START, DATA, STOP (plus PARITY, see REQ-024).
REQ-013 IDLE with THR-valid=1 at an edge SHALL transition to START, copy THR into the shift register, clear THR-valid, load baud counter and drive UART_TXD <= 0.
REQ-014 START SHALL hold UART_TXD=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-015 DATA SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit bit counter; after bit 7 go to STOP.
REQ-016 STOP SHALL hold UART_TXD=1 for CLKS_PER_BIT cycles; on its final cycle go to START (same actions as REQ-013) if THR-valid=1, else IDLE.
REQ-017 Back-to-back bytes SHALL have zero idle cycles between stop bit and next start bit; frame = 10*CLKS_PER_BIT cycles.
REQ-018 Latency: load accepted at edge N -> UART_TE low after N; if IDLE, UART_TXD low and UART_TE high after edge N+1.
REQ-019 Baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits, count down to 0, reload on each bit boundary; no wrap past 0.
REQ-020 A load accepted in the same cycle the FSM transfers THR to the shifter is impossible (UART_TE=0 then) and SHALL not be handled specially.

Reset
REQ-021 reset=1 at an edge SHALL force state IDLE, THR-valid=0, counters 0, shift register 0, UART_TXD=1, UART_TE=1, UART_busy=0.
REQ-022 Reset mid-frame SHALL abort the frame immediately (line high next cycle) and discard THR; no resumption after reset deasserts.
REQ-023 UART_load asserted during reset SHALL be ignored.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined: state PARITY inserted between DATA and STOP sending even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT; undefined: no PARITY state, frame = 10*CLKS_PER_BIT.

Verification (CLKS_PER_BIT=4)
REQ-025 Reset asserted 3 cycles, released -> UART_TXD=1, UART_TE=1, UART_busy=0, line stays high 100 cycles with no load.
REQ-026 Load 0x55 while idle -> UART_TXD = 0,1,0,1,0,1,0,1,0,1 each held 4 cycles; UART_TE high again 1 cycle after acceptance; busy high exactly 40 cycles.
REQ-027 Load 0xA5, then 0x3C 5 cycles later -> both frames contiguous, 80 cycles busy, no high gap beyond stop bit; UART_TE low from 2nd load until 2nd frame start.
REQ-028 Load 0xA5, 0x3C, then 0xFF while UART_TE=0 -> 0xFF never transmitted; only 0xA5, 0x3C appear on line.
REQ-029 Reset pulsed during DATA bit 3 of 0x0F with THR holding 0x33 -> UART_TXD=1 next cycle, UART_TE=1, 0x33 never sent.
REQ-030 UART_TX_PARITY_EN defined, load 0x07 -> parity bit 1 after bit 7; load 0x03 -> parity bit 0; frame 44 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 with a one-byte holding register, back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_load,
  input  logic [7:0] UART_din,
  output logic       UART_TE,
  output logic       UART_TXD,
  output logic       UART_busy
);

  localparam int unsigned CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      thr_q, thr_d;
  logic            thr_vld_q, thr_vld_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic            txd_q, txd_d;
  logic            bit_end;
  logic            start_go;

  assign bit_end  = (baud_q == '0);
  // A new frame starts from idle, or seamlessly on the last stop-bit cycle.
  assign start_go = thr_vld_q &&
                    ((state_q == S_IDLE) ||
                     ((state_q == S_STOP) && bit_end));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      thr_q     <= '0;
      thr_vld_q <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      baud_q    <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      thr_q     <= thr_d;
      thr_vld_q <= thr_vld_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      txd_q     <= txd_d;
    end
  end

  // Next-state logic: advance one bit period at a time
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (thr_vld_q) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end && (bit_cnt_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP: begin
        if (bit_end) state_d = thr_vld_q ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: holding register, rotating shifter, baud and bit counters
  always_comb begin
    thr_d     = thr_q;
    thr_vld_d = thr_vld_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    txd_d     = txd_q;
    if (UART_load && !thr_vld_q) begin
      thr_d     = UART_din;
      thr_vld_d = 1'b1;
    end
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? BAUD_MAX : baud_q - CW'(1);
    end
    unique case (state_q)
      S_IDLE: ;
      S_START: begin
        if (bit_end) begin
          txd_d     = shift_q[0];
          shift_d   = {shift_q[0], shift_q[7:1]};
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q != 3'd7) begin
            txd_d     = shift_q[0];
            shift_d   = {shift_q[0], shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            // Eight rotations restore the byte, so parity is direct.
`ifdef UART_TX_PARITY_EN
            txd_d = ^shift_q;
`else
            txd_d = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) txd_d = 1'b1;
`endif
      S_STOP: begin
        if (bit_end) begin
          txd_d  = 1'b1;
          baud_d = '0;
        end
      end
      default: ;
    endcase
    if (start_go) begin
      shift_d   = thr_q;
      thr_vld_d = 1'b0;
      baud_d    = BAUD_MAX;
      txd_d     = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    UART_TE   = !thr_vld_q;
    UART_busy = (state_q != S_IDLE);
    UART_TXD  = txd_q;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with CLKS_PER_BIT=4 against a schedule-level model.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int FC = F * C;
  localparam int MAXN = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       UART_load = 1'b0;
  logic [7:0] UART_din = 8'h00;
  logic       UART_TE, UART_TXD, UART_busy;

  int checks = 0;
  int failures = 0;

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .reset(reset),
    .UART_load(UART_load),
    .UART_din(UART_din),
    .UART_TE(UART_TE),
    .UART_TXD(UART_TXD),
    .UART_busy(UART_busy)
  );

  always #5 clk = ~clk;

  logic obs_line[MAXN], obs_busy[MAXN], obs_te[MAXN];
  logic exp_line[MAXN], exp_busy[MAXN], exp_te[MAXN];
  int         sch_t[$];
  logic [7:0] sch_b[$];

  // Line level of frame bit i for byte b
  function automatic logic fb(logic [7:0] b, int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive scheduled loads (edge index relative to start) and record outputs
  task automatic run_sched(int n);
    int k;
    k = 0;
    for (int e = 0; e < n; e++) begin
      if (k < sch_t.size() && sch_t[k] == e) begin
        UART_load = 1'b1;
        UART_din  = sch_b[k];
        k++;
      end else begin
        UART_load = 1'b0;
        UART_din  = 8'($urandom);
      end
      tick;
      obs_line[e] = UART_TXD;
      obs_busy[e] = UART_busy;
      obs_te[e]   = UART_TE;
    end
    UART_load = 1'b0;
  endtask

  // Model: a load is taken unless an earlier byte still waits in the
  // holding register; each frame starts at the later of (accept+1) and
  // the end of the previous frame.
  task automatic build_model(int n);
    int acc_a[$];
    int acc_s[$];
    logic [7:0] acc_b[$];
    int prev_end, a, s;
    prev_end = 0;
    for (int k = 0; k < sch_t.size(); k++) begin
      a = sch_t[k];
      if (acc_a.size() > 0 && acc_a[$] < a && a <= acc_s[$]) continue;
      s = (a + 1 > prev_end) ? a + 1 : prev_end;
      prev_end = s + FC;
      acc_a.push_back(a);
      acc_s.push_back(s);
      acc_b.push_back(sch_b[k]);
    end
    for (int e = 0; e < n; e++) begin
      exp_line[e] = 1'b1;
      exp_busy[e] = 1'b0;
      exp_te[e]   = 1'b1;
      for (int i = 0; i < acc_a.size(); i++) begin
        if (e >= acc_s[i] && e < acc_s[i] + FC) begin
          exp_line[e] = fb(acc_b[i], (e - acc_s[i]) / C);
          exp_busy[e] = 1'b1;
        end
        if (e >= acc_a[i] && e < acc_s[i]) exp_te[e] = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    UART_load = 1'b1;
    UART_din  = 8'hAA;
    repeat (3) tick;
    reset     = 1'b0;
    UART_load = 1'b0;
    checks++;
    if ({UART_TXD, UART_TE, UART_busy} !== 3'b110) begin
      failures++;
      $display("FAIL reset_state txd/te/busy got %b%b%b exp 110",
               UART_TXD, UART_TE, UART_busy);
    end
    for (int i = 0; i < 100; i++) begin
      tick;
      checks++;
      if (UART_TXD !== 1'b1 || UART_busy !== 1'b0 || UART_TE !== 1'b1) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d txd/te/busy got %b%b%b exp 110",
                 i, UART_TXD, UART_TE, UART_busy);
      end
    end
  endtask

  task automatic test_single;
    int n, cnt;
    n = FC + 10;
    sch_t = {0};
    sch_b = {8'h55};
    run_sched(n);
    build_model(n);
    cnt = 0;
    for (int e = 0; e < n; e++) begin
      cnt += int'(obs_busy[e]);
      checks++;
      if ({obs_line[e], obs_busy[e], obs_te[e]} !==
          {exp_line[e], exp_busy[e], exp_te[e]}) begin
        failures++;
        $display("FAIL single cyc=%0d line/busy/te got %b%b%b exp %b%b%b", e,
                 obs_line[e], obs_busy[e], obs_te[e],
                 exp_line[e], exp_busy[e], exp_te[e]);
      end
    end
    checks++;
    if (obs_te[0] !== 1'b0 || obs_te[1] !== 1'b1 || obs_line[1] !== 1'b0) begin
      failures++;
      $display("FAIL single_latency te0/te1/line1 got %b%b%b exp 010",
               obs_te[0], obs_te[1], obs_line[1]);
    end
    checks++;
    if (cnt != FC) begin
      failures++;
      $display("FAIL single_busy_len got %0d exp %0d", cnt, FC);
    end
  endtask

  task automatic test_back_to_back;
    int n, cnt;
    n = 2 * FC + 10;
    sch_t = {0, 5};
    sch_b = {8'hA5, 8'h3C};
    run_sched(n);
    build_model(n);
    cnt = 0;
    for (int e = 0; e < n; e++) begin
      cnt += int'(obs_busy[e]);
      checks++;
      if ({obs_line[e], obs_busy[e], obs_te[e]} !==
          {exp_line[e], exp_busy[e], exp_te[e]}) begin
        failures++;
        $display("FAIL b2b cyc=%0d line/busy/te got %b%b%b exp %b%b%b", e,
                 obs_line[e], obs_busy[e], obs_te[e],
                 exp_line[e], exp_busy[e], exp_te[e]);
      end
    end
    checks++;
    if (cnt != 2 * FC || obs_line[1 + FC] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_contig busy=%0d start2=%b exp busy=%0d start2=0",
               cnt, obs_line[1 + FC], 2 * FC);
    end
  endtask

  task automatic test_overrun;
    int n, cnt;
    n = 3 * FC + 10;
    sch_t = {0, 5, 10};
    sch_b = {8'hA5, 8'h3C, 8'hFF};
    run_sched(n);
    build_model(n);
    cnt = 0;
    for (int e = 0; e < n; e++) begin
      cnt += int'(obs_busy[e]);
      checks++;
      if ({obs_line[e], obs_busy[e], obs_te[e]} !==
          {exp_line[e], exp_busy[e], exp_te[e]}) begin
        failures++;
        $display("FAIL overrun cyc=%0d line/busy/te got %b%b%b exp %b%b%b", e,
                 obs_line[e], obs_busy[e], obs_te[e],
                 exp_line[e], exp_busy[e], exp_te[e]);
      end
    end
    checks++;
    if (cnt != 2 * FC) begin
      failures++;
      $display("FAIL overrun_busy_len got %0d exp %0d", cnt, 2 * FC);
    end
  endtask

  task automatic test_random;
    int n, t;
    for (int r = 0; r < 4; r++) begin
      sch_t.delete();
      sch_b.delete();
      t = int'($urandom_range(0, 3));
      for (int k = 0; k < 8; k++) begin
        sch_t.push_back(t);
        sch_b.push_back(8'($urandom));
        t += int'($urandom_range(1, 30));
      end
      n = t + 9 * FC + 10;
      if (n > MAXN) n = MAXN;
      run_sched(n);
      build_model(n);
      for (int e = 0; e < n; e++) begin
        checks++;
        if ({obs_line[e], obs_busy[e], obs_te[e]} !==
            {exp_line[e], exp_busy[e], exp_te[e]}) begin
          failures++;
          $display("FAIL random r=%0d cyc=%0d line/busy/te got %b%b%b exp %b%b%b",
                   r, e, obs_line[e], obs_busy[e], obs_te[e],
                   exp_line[e], exp_busy[e], exp_te[e]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    UART_load = 1'b1;
    UART_din  = 8'h0F;
    tick;
    UART_load = 1'b0;
    tick;
    tick;
    UART_load = 1'b1;
    UART_din  = 8'h33;
    tick;
    UART_load = 1'b0;
    repeat (14) tick;
    checks++;
    if (UART_TXD !== 1'b1 || UART_TE !== 1'b0 || UART_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre txd/te/busy got %b%b%b exp 101",
               UART_TXD, UART_TE, UART_busy);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({UART_TXD, UART_TE, UART_busy} !== 3'b110) begin
      failures++;
      $display("FAIL mid_abort txd/te/busy got %b%b%b exp 110",
               UART_TXD, UART_TE, UART_busy);
    end
    for (int i = 0; i < 60; i++) begin
      tick;
      checks++;
      if (UART_TXD !== 1'b1 || UART_busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_after cyc=%0d txd/busy got %b%b exp 10",
                 i, UART_TXD, UART_busy);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int n, cnt;
    n = 60 + FC + 10;
    sch_t = {0, 60};
    sch_b = {8'h07, 8'h03};
    run_sched(n);
    build_model(n);
    cnt = 0;
    for (int e = 0; e < n; e++) begin
      cnt += int'(obs_busy[e]);
      checks++;
      if ({obs_line[e], obs_busy[e], obs_te[e]} !==
          {exp_line[e], exp_busy[e], exp_te[e]}) begin
        failures++;
        $display("FAIL parity cyc=%0d line/busy/te got %b%b%b exp %b%b%b", e,
                 obs_line[e], obs_busy[e], obs_te[e],
                 exp_line[e], exp_busy[e], exp_te[e]);
      end
    end
    checks++;
    if (obs_line[37] !== 1'b1 || obs_line[97] !== 1'b0 || cnt != 88) begin
      failures++;
      $display("FAIL parity_bits p07=%b p03=%b busy=%0d exp 1 0 88",
               obs_line[37], obs_line[97], cnt);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overrun;
    test_random;
    test_reset_mid;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
